// File: rtl/regfile.sv
// RV32I integer register file: 31 writable registers (x1..x31), x0 reads as zero,
// two combinational read ports and one write port committed on the rising edge.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rr1,
    input  logic [4:0]      rr2,
    input  logic [4:0]      wrr,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wrdata,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];

    // Next-state: at most one register takes the write data; x0 has no storage.
    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en && (wrr == i[4:0])) begin
                regs_d[i] = wrdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register storage with synchronous active-low clear that overrides any write.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            if (!rst_n) begin
                regs_q[i] <= {XLEN{1'b0}};
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: address 0 and unmapped addresses fall through to zero.
    always_comb begin
        rdata1 = {XLEN{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            if (rr1 == i[4:0]) begin
                rdata1 = regs_q[i];
            end else begin
                rdata1 = rdata1;
            end
        end
    end

    // Read port 2: independent copy of the port 1 selection.
    always_comb begin
        rdata2 = {XLEN{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            if (rr2 == i[4:0]) begin
                rdata2 = regs_q[i];
            end else begin
                rdata2 = rdata2;
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the driver pushes expected read data from an
// array model; a monitor on the falling edge pops and compares.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rr1, rr2, wrr;
    logic        wr_en;
    logic [31:0] wrdata;
    logic [31:0] rdata1, rdata2;

    regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rr1    (rr1),
        .rr2    (rr2),
        .wrr    (wrr),
        .wr_en  (wr_en),
        .wrdata (wrdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] dvals [32];

    // One cycle: drive inputs, predict pre-edge reads, then apply the edge to the model.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2, input string tag);
        exp_t e;
        rst_n  = rst;
        wr_en  = we;
        wrr    = wa;
        wrdata = wd;
        rr1    = a1;
        rr2    = a2;
        e.e1   = model[a1];
        e.e2   = model[a2];
        e.tag  = tag;
        exp_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        if (!rst) begin
            for (int i = 1; i < 32; i++) model[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
    endtask

    // Monitor: compare every pending expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata1 !== e.e1) begin
                    errors++;
                    $display("FAIL %s rdata1 rr1=%0d got %h exp %h", e.tag, rr1, rdata1, e.e1);
                end
                checks++;
                if (rdata2 !== e.e2) begin
                    errors++;
                    $display("FAIL %s rdata2 rr2=%0d got %h exp %h", e.tag, rr2, rdata2, e.e2);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst_n = 1'b0; wr_en = 1'b0; wrr = 5'd0; wrdata = 32'h0; rr1 = 5'd0; rr2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 32; i += 2)
            step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), "reset_sweep");

        step(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, "x0_write");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "x0_read");

        for (int i = 1; i < 32; i++) begin
            dvals[i] = $urandom;
            step(1'b1, 1'b1, 5'(i), dvals[i], 5'(i), 5'd0, "wb_write");
            step(1'b1, 1'b0, 5'(i), 32'h0, 5'(i), 5'(i), "wb_read");
        end
        for (int i = 1; i < 32; i++)
            step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), "wb_retain");

        step(1'b1, 1'b1, 5'd5, 32'h12345678, 5'd0, 5'd0, "dual_w5");
        step(1'b1, 1'b1, 5'd6, 32'h9ABCDEF0, 5'd0, 5'd0, "dual_w6");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, "dual_5_6");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd6, 5'd6, "dual_6_6");

        step(1'b1, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, "we_setup");
        step(1'b1, 1'b0, 5'd7, 32'h22222222, 5'd7, 5'd7, "we_off_pre");
        step(1'b1, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, "nobypass_pre");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "write_post");

        step(1'b1, 1'b1, 5'd8, 32'hA5A5A5A5, 5'd8, 5'd0, "b2b_w1");
        step(1'b1, 1'b1, 5'd8, 32'h5A5A5A5A, 5'd8, 5'd0, "b2b_w2");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0, "b2b_last");

        step(1'b1, 1'b1, 5'd3, 32'hAAAAAAAA, 5'd3, 5'd0, "rstw_setup");
        step(1'b0, 1'b1, 5'd3, 32'h55555555, 5'd3, 5'd3, "rstw_pre");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "rstw_post");

        for (int n = 0; n < 300; n++)
            step(($urandom_range(0, 40) != 0), 1'($urandom), 5'($urandom), $urandom,
                 5'($urandom), 5'($urandom), "random");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
